// File: rtl/ise_sort_engine.sv
// Image sorting engine: classifies each streamed image by dominant colour, ranks it by class and key.
// Optional key_out port enabled by defining ISE_KEY_OUT_EN.
module ise_sort_engine #(
  parameter int IMAGE_NUM  = 32,
  parameter int IMAGE_SIZE = 128,
  parameter int PIX_W      = 8,
  localparam int IDX_W       = $clog2(IMAGE_NUM),
  localparam int PIX_PER_IMG = IMAGE_SIZE * IMAGE_SIZE,
  localparam int CNT_W       = $clog2(PIX_PER_IMG + 1),
  localparam int KEY_W       = PIX_W + $clog2(PIX_PER_IMG)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pixel_valid,
  input  logic [IDX_W-1:0]   image_in_index,
  input  logic [3*PIX_W-1:0] pixel_in,
  input  logic               sort_desc,
`ifdef ISE_KEY_OUT_EN
  output logic [KEY_W-1:0]   key_out,
`endif
  output logic               busy,
  output logic               out_valid,
  output logic [1:0]         color_index,
  output logic [IDX_W-1:0]   image_out_index
);

  typedef enum logic [1:0] {ACCUM, CLASSIFY, INSERT, OUTPUT} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [IDX_W:0]   img_cnt_q, img_cnt_d;
  logic [IDX_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [KEY_W-1:0] sum_q [3];
  logic [KEY_W-1:0] sum_d [3];
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic             desc_q, desc_d;
  logic [1:0]       new_cls_q, new_cls_d;
  logic [KEY_W-1:0] new_key_q, new_key_d;

  logic [1:0]       l_cls_q [IMAGE_NUM];
  logic [1:0]       l_cls_d [IMAGE_NUM];
  logic [KEY_W-1:0] l_key_q [IMAGE_NUM];
  logic [KEY_W-1:0] l_key_d [IMAGE_NUM];
  logic [IDX_W-1:0] l_idx_q [IMAGE_NUM];
  logic [IDX_W-1:0] l_idx_d [IMAGE_NUM];
  logic [1:0]       p_cls [IMAGE_NUM];
  logic [KEY_W-1:0] p_key [IMAGE_NUM];
  logic [IDX_W-1:0] p_idx [IMAGE_NUM];
  logic [IMAGE_NUM-1:0] ahead;
  logic [IMAGE_NUM:0]   lead;

  logic             busy_q, busy_d;
  logic             ov_q, ov_d;
  logic [1:0]       color_q, color_d;
  logic [IDX_W-1:0] img_out_q, img_out_d;
`ifdef ISE_KEY_OUT_EN
  logic [KEY_W-1:0] key_out_q, key_out_d;
`endif

  logic [PIX_W-1:0] px_r, px_g, px_b;
  logic [1:0]       pix_cls;
  logic             accept, last_pix, out_last;

  // Argmax with ties resolved R > G > B
  function automatic logic [1:0] argmax3(
    input logic [KEY_W-1:0] a,
    input logic [KEY_W-1:0] b,
    input logic [KEY_W-1:0] c
  );
    logic sel_a, sel_b;
    sel_a = (a >= b) && (a >= c);
    sel_b = !sel_a && (b >= c);
    unique case (1'b1)
      sel_a:   return 2'd0;
      sel_b:   return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  assign px_r     = pixel_in[3*PIX_W-1 -: PIX_W];
  assign px_g     = pixel_in[2*PIX_W-1 -: PIX_W];
  assign px_b     = pixel_in[PIX_W-1:0];
  assign pix_cls  = argmax3(KEY_W'(px_r), KEY_W'(px_g), KEY_W'(px_b));
  assign accept   = pixel_valid && !busy_q && (state_q == ACCUM);
  assign last_pix = (pix_cnt_q == CNT_W'(PIX_PER_IMG - 1));
  assign out_last = (out_cnt_q == IDX_W'(IMAGE_NUM - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:    if (accept && last_pix) state_d = CLASSIFY;
      CLASSIFY: state_d = INSERT;
      INSERT:   state_d = (img_cnt_q == (IDX_W+1)'(IMAGE_NUM - 1)) ? OUTPUT : ACCUM;
      OUTPUT:   if (out_last) state_d = ACCUM;
      default:  state_d = ACCUM;
    endcase
  end

  always_comb begin
    ov_d      = (state_q == OUTPUT);
    color_d   = ov_d ? l_cls_q[0] : color_q;
    img_out_d = ov_d ? l_idx_q[0] : img_out_q;
`ifdef ISE_KEY_OUT_EN
    key_out_d = ov_d ? l_key_q[0] : key_out_q;
`endif
    // Stays high through the final result cycle so no pixel overlaps it
    busy_d    = (state_d != ACCUM) || ov_d;
  end

  // An existing entry stays ahead of the new one; ahead[] is a prefix of the list
  always_comb begin
    ahead = '0;
    for (int i = 0; i < IMAGE_NUM; i++) begin
      if ((IDX_W+1)'(i) < img_cnt_q) begin
        if (l_cls_q[i] < new_cls_q) begin
          ahead[i] = 1'b1;
        end else if (l_cls_q[i] == new_cls_q) begin
          ahead[i] = desc_q ? (l_key_q[i] >= new_key_q)
                            : (l_key_q[i] <= new_key_q);
        end
      end
    end
    lead     = {ahead, 1'b1};
    p_cls[0] = '0;
    p_key[0] = '0;
    p_idx[0] = '0;
    for (int i = 1; i < IMAGE_NUM; i++) begin
      p_cls[i] = l_cls_q[i-1];
      p_key[i] = l_key_q[i-1];
      p_idx[i] = l_idx_q[i-1];
    end
  end

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    img_cnt_d = img_cnt_q;
    out_cnt_d = out_cnt_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cur_idx_d = cur_idx_q;
    desc_d    = desc_q;
    new_cls_d = new_cls_q;
    new_key_d = new_key_q;
    l_cls_d   = l_cls_q;
    l_key_d   = l_key_q;
    l_idx_d   = l_idx_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          if (pix_cnt_q == '0) begin
            cur_idx_d = image_in_index;
            desc_d    = sort_desc;
          end
          for (int c = 0; c < 3; c++) begin
            if (pix_cls == 2'(c)) cnt_d[c] = cnt_q[c] + CNT_W'(1);
          end
          sum_d[0]  = sum_q[0] + KEY_W'(px_r);
          sum_d[1]  = sum_q[1] + KEY_W'(px_g);
          sum_d[2]  = sum_q[2] + KEY_W'(px_b);
          pix_cnt_d = last_pix ? '0 : pix_cnt_q + CNT_W'(1);
        end
      end
      CLASSIFY: begin
        new_cls_d = argmax3(KEY_W'(cnt_q[0]), KEY_W'(cnt_q[1]),
                            KEY_W'(cnt_q[2]));
        new_key_d = (new_cls_d == 2'd0) ? sum_q[0] :
                    (new_cls_d == 2'd1) ? sum_q[1] : sum_q[2];
      end
      INSERT: begin
        for (int i = 0; i < IMAGE_NUM; i++) begin
          if (!ahead[i]) begin
            if (lead[i]) begin
              l_cls_d[i] = new_cls_q;
              l_key_d[i] = new_key_q;
              l_idx_d[i] = cur_idx_q;
            end else begin
              l_cls_d[i] = p_cls[i];
              l_key_d[i] = p_key[i];
              l_idx_d[i] = p_idx[i];
            end
          end
        end
        cnt_d     = '{default: '0};
        sum_d     = '{default: '0};
        img_cnt_d = img_cnt_q + (IDX_W+1)'(1);
      end
      OUTPUT: begin
        for (int i = 0; i < IMAGE_NUM - 1; i++) begin
          l_cls_d[i] = l_cls_q[i+1];
          l_key_d[i] = l_key_q[i+1];
          l_idx_d[i] = l_idx_q[i+1];
        end
        l_cls_d[IMAGE_NUM-1] = '0;
        l_key_d[IMAGE_NUM-1] = '0;
        l_idx_d[IMAGE_NUM-1] = '0;
        out_cnt_d = out_cnt_q + IDX_W'(1);
        if (out_last) begin
          l_cls_d   = '{default: '0};
          l_key_d   = '{default: '0};
          l_idx_d   = '{default: '0};
          img_cnt_d = '0;
          out_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_cnt_q <= '0;
      img_cnt_q <= '0;
      out_cnt_q <= '0;
      cnt_q     <= '{default: '0};
      sum_q     <= '{default: '0};
      cur_idx_q <= '0;
      desc_q    <= 1'b0;
      new_cls_q <= '0;
      new_key_q <= '0;
      l_cls_q   <= '{default: '0};
      l_key_q   <= '{default: '0};
      l_idx_q   <= '{default: '0};
      busy_q    <= 1'b0;
      ov_q      <= 1'b0;
      color_q   <= '0;
      img_out_q <= '0;
`ifdef ISE_KEY_OUT_EN
      key_out_q <= '0;
`endif
    end else begin
      pix_cnt_q <= pix_cnt_d;
      img_cnt_q <= img_cnt_d;
      out_cnt_q <= out_cnt_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      cur_idx_q <= cur_idx_d;
      desc_q    <= desc_d;
      new_cls_q <= new_cls_d;
      new_key_q <= new_key_d;
      l_cls_q   <= l_cls_d;
      l_key_q   <= l_key_d;
      l_idx_q   <= l_idx_d;
      busy_q    <= busy_d;
      ov_q      <= ov_d;
      color_q   <= color_d;
      img_out_q <= img_out_d;
`ifdef ISE_KEY_OUT_EN
      key_out_q <= key_out_d;
`endif
    end
  end

  assign busy            = busy_q;
  assign out_valid       = ov_q;
  assign color_index     = color_q;
  assign image_out_index = img_out_q;
`ifdef ISE_KEY_OUT_EN
  assign key_out         = key_out_q;
`endif

endmodule

// File: tb/tb_ise_sort_engine.sv
// Self-checking bench for ise_sort_engine: directed scenarios plus random batches
// against a sort-based reference model.
module tb_ise_sort_engine;

  localparam int N   = 4;
  localparam int SZ  = 2;
  localparam int PW  = 8;
  localparam int IW  = 2;
  localparam int PPI = SZ * SZ;
  localparam int KW  = PW + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          pixel_valid;
  logic [IW-1:0] image_in_index;
  logic [23:0]   pixel_in;
  logic          sort_desc;
  logic          busy;
  logic          out_valid;
  logic [1:0]    color_index;
  logic [IW-1:0] image_out_index;
`ifdef ISE_KEY_OUT_EN
  logic [KW-1:0] key_out;
`endif

  int errors = 0;
  int checks = 0;

  logic [23:0] pix [N][PPI];
  int img_idx [N];
  int exp_cls [N];
  int exp_key [N];
  int exp_idx [N];

  ise_sort_engine #(.IMAGE_NUM(N), .IMAGE_SIZE(SZ), .PIX_W(PW)) dut (
    .clk            (clk),
    .reset          (reset),
    .pixel_valid    (pixel_valid),
    .image_in_index (image_in_index),
    .pixel_in       (pixel_in),
    .sort_desc      (sort_desc),
`ifdef ISE_KEY_OUT_EN
    .key_out        (key_out),
`endif
    .busy           (busy),
    .out_valid      (out_valid),
    .color_index    (color_index),
    .image_out_index(image_out_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] rgb(input int r, input int g, input int b);
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  // Reference: classify each image, then stable-sort by (class, key direction)
  task automatic model(input bit desc);
    int ord [N];
    int cls [N];
    int key [N];
    for (int i = 0; i < N; i++) begin
      int cnt [3];
      int sum [3];
      cnt = '{0, 0, 0};
      sum = '{0, 0, 0};
      for (int p = 0; p < PPI; p++) begin
        int r, g, b;
        r = int'(pix[i][p][23:16]);
        g = int'(pix[i][p][15:8]);
        b = int'(pix[i][p][7:0]);
        sum[0] += r; sum[1] += g; sum[2] += b;
        if (r >= g && r >= b) cnt[0]++;
        else if (g >= b) cnt[1]++;
        else cnt[2]++;
      end
      if (cnt[0] >= cnt[1] && cnt[0] >= cnt[2]) cls[i] = 0;
      else if (cnt[1] >= cnt[2]) cls[i] = 1;
      else cls[i] = 2;
      key[i] = sum[cls[i]];
      ord[i] = i;
    end
    for (int pass = 0; pass < N; pass++) begin
      for (int j = 0; j < N - 1; j++) begin
        int a, b;
        bit after;
        a = ord[j];
        b = ord[j+1];
        after = (cls[a] > cls[b]) ||
                (cls[a] == cls[b] && (desc ? key[a] < key[b] : key[a] > key[b]));
        if (after) begin
          ord[j]   = b;
          ord[j+1] = a;
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      exp_cls[k] = cls[ord[k]];
      exp_key[k] = key[ord[k]];
      exp_idx[k] = img_idx[ord[k]];
    end
  endtask

  task automatic check_reset_state();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_color", 32'(color_index), 0);
    chk("rst_img_idx", 32'(image_out_index), 0);
`ifdef ISE_KEY_OUT_EN
    chk("rst_key", 32'(key_out), 0);
`endif
  endtask

  // Starts and ends at a negedge; npix pixels of image i are offered
  task automatic send_image(input int i, input int npix, input bit gaps,
                            input bit chg);
    chk("idle_out_valid", 32'(out_valid), 0);
    for (int p = 0; p < npix; p++) begin
      int g;
      g = 0;
      while (busy !== 1'b0 && g < 20) begin
        @(negedge clk);
        g++;
      end
      if (g >= 20) chk("busy_timeout", 32'(busy), 0);
      if (gaps) begin
        pixel_valid = 1'b0;
        pixel_in    = 24'($urandom);
        @(negedge clk);
      end
      pixel_valid    = 1'b1;
      pixel_in       = pix[i][p];
      image_in_index = (chg && p > 0) ? IW'(img_idx[i] + 1) : IW'(img_idx[i]);
      @(negedge clk);
      pixel_valid = 1'b0;
      pixel_in    = 24'($urandom);
    end
  endtask

  task automatic run_batch(input bit desc, input bit gaps, input bit chg,
                           input string tag);
    sort_desc = desc;
    model(desc);
    for (int i = 0; i < N - 1; i++) begin
      send_image(i, PPI, gaps, chg);
      chk({tag, "_busy_cls"}, 32'(busy), 1);
      @(negedge clk);
      chk({tag, "_busy_ins"}, 32'(busy), 1);
      @(negedge clk);
      chk({tag, "_busy_acc"}, 32'(busy), 0);
    end
    send_image(N - 1, PPI, gaps, chg);
    chk({tag, "_lat0"}, 32'(out_valid), 0);
    repeat (2) begin
      @(negedge clk);
      chk({tag, "_lat"}, 32'(out_valid), 0);
    end
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk({tag, "_ov"}, 32'(out_valid), 1);
      chk({tag, "_busy_out"}, 32'(busy), 1);
      chk({tag, "_color"}, 32'(color_index), 32'(exp_cls[k]));
      chk({tag, "_index"}, 32'(image_out_index), 32'(exp_idx[k]));
`ifdef ISE_KEY_OUT_EN
      chk({tag, "_key"}, 32'(key_out), 32'(exp_key[k]));
`endif
    end
    @(negedge clk);
    chk({tag, "_ov_end"}, 32'(out_valid), 0);
    chk({tag, "_busy_end"}, 32'(busy), 0);
    chk({tag, "_color_hold"}, 32'(color_index), 32'(exp_cls[N-1]));
    chk({tag, "_index_hold"}, 32'(image_out_index), 32'(exp_idx[N-1]));
  endtask

  task automatic load_pure_r();
    int rv [N];
    rv = '{40, 10, 30, 20};
    for (int i = 0; i < N; i++) begin
      img_idx[i] = i;
      for (int p = 0; p < PPI; p++) pix[i][p] = rgb(rv[i], 0, 0);
    end
  endtask

  task automatic load_mixed();
    for (int i = 0; i < N; i++) img_idx[i] = i;
    for (int p = 0; p < PPI; p++) begin
      pix[0][p] = rgb(0, 0, 50);
      pix[1][p] = rgb(0, 50, 0);
      pix[2][p] = rgb(50, 0, 0);
      pix[3][p] = (p < 2) ? rgb(9, 9, 0) : rgb(0, 0, 200);
    end
  endtask

  function automatic int rand_chan();
    int v [4];
    v = '{0, 9, 50, 200};
    return v[$urandom_range(0, 3)];
  endfunction

  task automatic load_random();
    for (int i = 0; i < N; i++) begin
      img_idx[i] = int'($urandom_range(0, N - 1));
      for (int p = 0; p < PPI; p++)
        pix[i][p] = rgb(rand_chan(), rand_chan(), rand_chan());
    end
  endtask

  initial begin
    reset          = 1'b0;
    pixel_valid    = 1'b0;
    image_in_index = '0;
    pixel_in       = '0;
    sort_desc      = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state();
    reset = 1'b1;
    @(negedge clk);

    load_pure_r();
    run_batch(1'b0, 1'b0, 1'b0, "asc");
    chk("asc_head_ref", 32'(exp_idx[0]), 1);

    load_pure_r();
    run_batch(1'b1, 1'b0, 1'b0, "desc");

    load_mixed();
    run_batch(1'b0, 1'b0, 1'b0, "mixed");

    load_pure_r();
    run_batch(1'b0, 1'b1, 1'b1, "gaps");

    load_pure_r();
    sort_desc = 1'b0;
    send_image(0, PPI, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    send_image(1, 2, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state();
    reset = 1'b1;
    @(negedge clk);
    run_batch(1'b0, 1'b0, 1'b0, "after_rst");

    load_pure_r();
    run_batch(1'b0, 1'b0, 1'b0, "b2b1");
    load_mixed();
    run_batch(1'b0, 1'b0, 1'b0, "b2b2");

    for (int t = 0; t < 6; t++) begin
      load_random();
      run_batch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
